// File: rtl/zalu.sv
// rtl/zalu.sv - multi-cycle 8-bit ALU execute unit with START/BUSY/DONE handshake
// Optional feature macro: ZALU_MUL_EN builds the iterative shift-add multiplier for FUNC 111.
module zalu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       FUNC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [2:0]       FLAGS
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_XOR = 3'b100;
    localparam logic [2:0] F_SHL = 3'b101;
    localparam logic [2:0] F_SHR = 3'b110;
    localparam logic [2:0] F_MUL = 3'b111;

    localparam int CW = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;
`ifdef ZALU_MUL_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    logic [1:0]       state_q, state_d;
    logic [2:0]       func_q, func_d;
    logic [AW-1:0]    opa_q, opa_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shc_q, shc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;
`ifdef ZALU_MUL_EN
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [AW-1:0]    acc_q, acc_d;
`endif

    logic             finish;
    logic [WIDTH-1:0] res_v;
    logic             res_c;

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        opa_d    = opa_q;
        cnt_d    = cnt_q;
        shc_d    = shc_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ZALU_MUL_EN
        opb_d    = opb_q;
        acc_d    = acc_q;
`endif
        finish   = 1'b0;
        res_v    = '0;
        res_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    func_d = FUNC;
                    opa_d  = AW'(A);
                    shc_d  = 1'b0;
                    cnt_d  = CW'(B[2:0]);
                    finish = 1'b1;
                    res_v  = A;
`ifdef ZALU_MUL_EN
                    opb_d  = B;
                    acc_d  = '0;
`endif
                    case (FUNC)
                        F_ADD: {res_c, res_v} = {1'b0, A} + {1'b0, B};
                        F_SUB: begin
                            res_v = A - B;
                            res_c = (A < B);
                        end
                        F_AND: res_v = A & B;
                        F_OR:  res_v = A | B;
                        F_XOR: res_v = A ^ B;
                        // zero-count shifts complete immediately with RESULT = A, C = 0
                        F_SHL, F_SHR: finish = (B[2:0] == 3'd0);
                        F_MUL: begin
`ifdef ZALU_MUL_EN
                            finish = 1'b0;
                            cnt_d  = CW'(WIDTH);
`endif
                        end
                        default: ;
                    endcase
                    if (!finish) state_d = S_ITER;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
                case (func_q)
                    F_SHL: begin
                        shc_d = opa_q[WIDTH-1];
                        opa_d = AW'({opa_q[WIDTH-2:0], 1'b0});
                        res_v = opa_d[WIDTH-1:0];
                        res_c = shc_d;
                    end
                    F_SHR: begin
                        shc_d = opa_q[0];
                        opa_d = AW'({1'b0, opa_q[WIDTH-1:1]});
                        res_v = opa_d[WIDTH-1:0];
                        res_c = shc_d;
                    end
`ifdef ZALU_MUL_EN
                    F_MUL: begin
                        acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                        res_v = acc_d[WIDTH-1:0];
                        res_c = |acc_d[AW-1:WIDTH];
                    end
`endif
                    default: ;
                endcase
                finish = (cnt_q == CW'(1));
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // outputs are registered on the edge that enters FIN, so they line up with DONE
        if (finish) begin
            state_d  = S_FIN;
            result_d = res_v;
            flags_d  = {res_v[WIDTH-1], res_c, (res_v == '0)};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            opa_q    <= '0;
            cnt_q    <= '0;
            shc_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ZALU_MUL_EN
            opb_q    <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            opa_q    <= opa_d;
            cnt_q    <= cnt_d;
            shc_q    <= shc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ZALU_MUL_EN
            opb_q    <= opb_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = (state_q == S_FIN);
    assign RESULT = result_q;
    assign FLAGS  = flags_q;

endmodule

// File: tb/tb_zalu.sv
// tb/tb_zalu.sv - self-checking bench for zalu with an expected-result scoreboard
module tb_zalu;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       START = 1'b0;
    logic [2:0] FUNC = 3'd0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [2:0] FLAGS;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] res;
        logic [2:0] flags;
        int         lat;
    } exp_t;

    exp_t sb[$];

    zalu #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNC(FUNC), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .FLAGS(FLAGS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [2:0] fl, input int lat);
        exp_t e;
        e.res = r;
        e.flags = fl;
        e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [7:0]  r;
        logic        c;
        int          n;
        int          lat;
        r = 8'd0;
        c = 1'b0;
        lat = 1;
        n = int'(b[2:0]);
        case (f)
            3'd0: {c, r} = {1'b0, a} + {1'b0, b};
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin p = {8'h00, a} << n; r = p[7:0];  c = (n == 0) ? 1'b0 : p[8]; lat = 1 + n; end
            3'd6: begin p = {a, 8'h00} >> n; r = p[15:8]; c = (n == 0) ? 1'b0 : p[7]; lat = 1 + n; end
            default: begin
`ifdef ZALU_MUL_EN
                p = {8'h00, a} * {8'h00, b};
                r = p[7:0];
                c = |p[15:8];
                lat = 9;
`else
                r = a;
`endif
            end
        endcase
        return mk(r, {r[7], c, (r == 8'd0)}, lat);
    endfunction

    task automatic wait_done(output int lat, output int busy_n, output int dones);
        lat = 0;
        busy_n = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            lat++;
            if (BUSY) busy_n++;
            if (DONE) begin
                dones++;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [7:0] a,
                          input logic [7:0] b, input exp_t e);
        exp_t g;
        int lat, bn, dn;
        sb.push_back(e);
        @(negedge CLK);
        FUNC = f; A = a; B = b; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        FUNC = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
        wait_done(lat, bn, dn);
        g = sb.pop_front();
        check({tag, ":result"}, 32'(RESULT), 32'(g.res));
        check({tag, ":flags"}, 32'(FLAGS), 32'(g.flags));
        check({tag, ":latency"}, 32'(lat), 32'(g.lat));
        check({tag, ":busy_cycles"}, 32'(bn), 32'(g.lat));
    endtask

    initial begin
        exp_t g;
        int lat, bn, dn;
        logic [2:0] lf;
        logic [7:0] la, lb;
        exp_t le;

`ifdef ZALU_MUL_EN
        lf = 3'b111; la = 8'h0F; lb = 8'h11; le = mk(8'hFF, 3'b100, 9);
`else
        lf = 3'b110; la = 8'h80; lb = 8'h07; le = mk(8'h01, 3'b000, 8);
`endif

        // reset state
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst:busy", 32'(BUSY), 32'd0);
        check("rst:done", 32'(DONE), 32'd0);
        check("rst:result", 32'(RESULT), 32'd0);
        check("rst:flags", 32'(FLAGS), 32'd0);
        RESET = 1'b1;

        // directed operations
        run_op("add", 3'b000, 8'hF0, 8'h20, mk(8'h10, 3'b010, 1));
        run_op("sub_eq", 3'b001, 8'h05, 8'h05, mk(8'h00, 3'b001, 1));
        run_op("sub_borrow", 3'b001, 8'h03, 8'h05, mk(8'hFE, 3'b110, 1));
        run_op("and", 3'b010, 8'hCA, 8'h0F, mk(8'h0A, 3'b000, 1));
        run_op("or", 3'b011, 8'h80, 8'h01, mk(8'h81, 3'b100, 1));
        run_op("xor", 3'b100, 8'h5A, 8'h5A, mk(8'h00, 3'b001, 1));
        run_op("shl3", 3'b101, 8'h81, 8'h03, mk(8'h08, 3'b000, 4));
        run_op("shr1", 3'b110, 8'h01, 8'h01, mk(8'h00, 3'b011, 2));
        run_op("shl0", 3'b101, 8'hC3, 8'hF8, mk(8'hC3, 3'b100, 1));
        run_op("shr7", 3'b110, 8'hC0, 8'h07, mk(8'h01, 3'b010, 8));
`ifdef ZALU_MUL_EN
        run_op("mul_ff", 3'b111, 8'h0F, 8'h11, mk(8'hFF, 3'b100, 9));
        run_op("mul_ovf", 3'b111, 8'h10, 8'h10, mk(8'h00, 3'b011, 9));
`else
        run_op("func7_pass", 3'b111, 8'h42, 8'h99, mk(8'h42, 3'b000, 1));
`endif

        for (int i = 0; i < 8; i++) begin
            logic [2:0] rf;
            logic [7:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, model(rf, ra, rb));
        end

        // START held high through a long op, operands swapped to an ADD during ITER
        sb.push_back(le);
        sb.push_back(mk(8'h33, 3'b000, 1));
        @(negedge CLK);
        FUNC = lf; A = la; B = lb; START = 1'b1;
        @(posedge CLK);
        #1;
        FUNC = 3'b000; A = 8'h11; B = 8'h22;
        wait_done(lat, bn, dn);
        g = sb.pop_front();
        check("hs:result", 32'(RESULT), 32'(g.res));
        check("hs:flags", 32'(FLAGS), 32'(g.flags));
        check("hs:latency", 32'(lat), 32'(g.lat));
        check("hs:done_count", 32'(dn), 32'd1);
        @(negedge CLK);
        check("hs:idle_busy", 32'(BUSY), 32'd0);
        check("hs:idle_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        g = sb.pop_front();
        check("hs2:done", 32'(DONE), 32'd1);
        check("hs2:result", 32'(RESULT), 32'(g.res));
        check("hs2:flags", 32'(FLAGS), 32'(g.flags));

        // outputs hold between operations
        repeat (3) @(negedge CLK);
        check("hold:result", 32'(RESULT), 32'h33);
        check("hold:done", 32'(DONE), 32'd0);

        // reset in the middle of a long operation
        @(negedge CLK);
        FUNC = lf; A = la; B = lb; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst:busy", 32'(BUSY), 32'd0);
        check("midrst:done", 32'(DONE), 32'd0);
        check("midrst:result", 32'(RESULT), 32'd0);
        check("midrst:flags", 32'(FLAGS), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge CLK);
            if (DONE) dn++;
        end
        check("midrst:no_done", 32'(dn), 32'd0);
        run_op("post_rst_add", 3'b000, 8'h7F, 8'h01, mk(8'h80, 3'b100, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/zalu.md
# zalu

Multi-cycle 8-bit ALU execute unit for the zephyr core.
- Consumes the two operand bytes read from the register file and a 3-bit function code decoded from an ALU-class instruction (opcode `11`).
- Produces an 8-bit result and Z/C/N flags, with a start/busy/done handshake.
- The core control FSM issues `START`, waits for `DONE`, then writes `RESULT` back to the register file and increments the PC.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; the shift counter and MUL iteration counter scale with it (MUL iterations = WIDTH).

Ports:
- `CLK`  input  1  core clock; all state updates on rising edge.
- `RESET`  input  1  synchronous, active-low reset; sampled on rising edge of `CLK`.
- `START`  input  1  request an operation; sampled only in IDLE.
- `FUNC`  input  3  function code, latched with `START`.
- `A`  input  WIDTH  operand A, latched with `START`.
- `B`  input  WIDTH  operand B, latched with `START`.
- `BUSY`  output  1  high from the cycle after `START` is accepted until `DONE` is high.
- `DONE`  output  1  one-cycle pulse; `RESULT`/`FLAGS` valid in this cycle and held after.
- `RESULT`  output  WIDTH  operation result.
- `FLAGS`  output  3  {N, C, Z}.

## Operation
Function codes:
- `000` ADD: {C, RESULT} = A + B.
- `001` SUB: RESULT = A − B mod 2^WIDTH; C = 1 on borrow (A < B unsigned).
- `010` AND, `011` OR, `100` XOR: C = 0.
- `101` SHL by B[2:0]: one bit per cycle; C = last bit shifted out (0 if count 0).
- `110` SHR (logical) by B[2:0]: one bit per cycle; C = last bit shifted out.
- `111` MUL: iterative shift-add, WIDTH iterations; RESULT = low byte of the product; C = 1 if the high byte is nonzero.

Flag rules (all functions):
- Z = (RESULT == 0).
- N = RESULT[WIDTH−1].

FSM states and transitions:
- IDLE, `START`=1: latch FUNC/A/B.
  - Single-cycle op, or shift with count 0: go to FIN.
  - Otherwise: load the iteration counter (shift count, or WIDTH for MUL) and go to ITER.
- ITER: perform one iteration per cycle and decrement the counter; go to FIN when the counter reaches 0 after decrement.
- FIN: assert `DONE`, update `RESULT` and `FLAGS`, return to IDLE.

Boundary conditions:
- `START` while not in IDLE (including during FIN) is ignored; no queueing.
- `START` may be reasserted in the cycle after `DONE`.
- FUNC/A/B changes after acceptance have no effect.
- Reset, including mid-operation: state = IDLE, `BUSY`=0, `DONE`=0, `RESULT`=0, `FLAGS`=000, counters and latches cleared.
- Outputs hold their last values between operations.

## Timing
- `START` sampled at edge t:
  - Single-cycle ops: `DONE` high during cycle t+1 (latency 1).
  - Shift by n ≥ 1: `DONE` in cycle t+1+n.
  - MUL: `DONE` in cycle t+1+WIDTH (t+9 for WIDTH=8).
- `BUSY` is high during cycles t+1 through the `DONE` cycle inclusive.
- `RESULT` and `FLAGS` change only on the edge that raises `DONE`.
- No combinational path from inputs to outputs.

## Configuration
- `ZALU_MUL_EN` defined: FUNC `111` is MUL as specified, and the multiplier datapath and iteration counter are compiled in.
- Not defined: MUL logic is absent, and FUNC `111` completes with latency 1 with RESULT = A, C = 0, and Z/N per the flag rules.

## Test plan
- ADD: A=0xF0, B=0x20, START at t -> `DONE` at t+1, RESULT=0x10, FLAGS N=0 C=1 Z=0.
- SUB: 0x05−0x05 -> RESULT=0x00, Z=1, C=0. Then 0x03−0x05 -> RESULT=0xFE, N=1, C=1.
- SHL: A=0x81, B=0x03 -> `BUSY` for 4 cycles, `DONE` at t+4, RESULT=0x08, C=0. SHR with A=0x01, B=0x01 -> RESULT=0x00, C=1, Z=1.
- MUL (`ZALU_MUL_EN` defined): 0x0F×0x11 -> 0xFF, N=1, C=0, `DONE` at t+9. 0x10×0x10 -> 0x00, Z=1, C=1. Without the macro: FUNC 111, A=0x42 -> RESULT=0x42 at t+1.
- Handshake: START held high throughout a MUL -> exactly one `DONE`; a second op is accepted only in the cycle after `DONE`. Operand changes during ITER do not alter RESULT.
- Reset: `RESET`=0 during ITER of a MUL -> next cycle `BUSY`=0, `DONE`=0, `RESULT`=0x00, `FLAGS`=000. No `DONE` follows; a fresh ADD afterwards completes normally.
